// File: rtl/zero_check_sched.sv
// Multi-cycle zero detect: two requesters share one external SLICE-wide NOR slice.
// The operand is scanned chunk by chunk, and the scan stops at the first non-zero chunk.
module zero_check_sched #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SLICE = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic [SLICE-1:0] slice_in,
  input  logic             slice_nor,
  output logic             resp_valid,
  output logic             resp_id,
  output logic             resp_zero,
  input  logic             resp_ready
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IdxW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NSLICE - 1);

  typedef enum logic [1:0] {StIdle, StScan, StResp} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] operand_q;
  logic [IdxW-1:0]  idx_q;
  logic             acc_q;
  logic             id_q;
  logic             last_grant_q;
  logic             grant;
  logic             accept;

  // Round-robin only matters under contention; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  always_comb begin
    req0_ready = (state_q == StIdle) && !reset && req0_valid && !grant;
    req1_ready = (state_q == StIdle) && !reset && req1_valid && grant;
    accept     = req0_ready || req1_ready;
  end

  always_comb begin
    slice_in = '0;
    if (state_q == StScan) begin
      slice_in = operand_q[idx_q * SLICE +: SLICE];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      operand_q    <= '0;
      idx_q        <= '0;
      acc_q        <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;  // requester 0 wins the first contended grant
      resp_valid   <= 1'b0;
      resp_id      <= 1'b0;
      resp_zero    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            operand_q    <= grant ? req1_data : req0_data;
            id_q         <= grant;
            last_grant_q <= grant;
            idx_q        <= '0;
            acc_q        <= 1'b1;
            state_q      <= StScan;
          end
        end
        StScan: begin
          acc_q <= acc_q & slice_nor;
          if (!slice_nor) begin
            resp_zero  <= 1'b0;
            resp_id    <= id_q;
            resp_valid <= 1'b1;
            state_q    <= StResp;
          end else if (idx_q == LastIdx) begin
            resp_zero  <= acc_q;
            resp_id    <= id_q;
            resp_valid <= 1'b1;
            state_q    <= StResp;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_zero_check_sched.sv
// Directed bench for zero_check_sched with an ideal NOR slice model.
module tb_zero_check_sched;
  localparam int unsigned WIDTH = 64;
  localparam int unsigned SLICE = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic [SLICE-1:0] slice_in;
  logic             slice_nor;
  logic             resp_valid, resp_id, resp_zero, resp_ready;

  int checks = 0;
  int errors = 0;
  logic [15:0] seen [0:31];

  always #5 clk = ~clk;
  assign slice_nor = (slice_in == '0);

  zero_check_sched #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .slice_in(slice_in), .slice_nor(slice_nor),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_zero(resp_zero),
    .resp_ready(resp_ready)
  );

  function automatic int exp_lat(input logic [63:0] d);
    for (int k = 0; k < 4; k++) if (d[k*16 +: 16] != 16'h0) return k + 1;
    return 4;
  endfunction

  // Called at a negedge with valid(s) driven; returns at the negedge after the accept edge.
  task automatic wait_accept(output bit got, output int waited, output bit to);
    got = 1'b0; waited = 0; to = 1'b1;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (req0_ready || req1_ready) begin
        got = req1_ready; waited = n; to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    if (!to) @(negedge clk);
  endtask

  task automatic wait_resp(output int lat, output bit to);
    lat = 0; to = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (resp_valid) begin
        to = 1'b0;
        break;
      end
      seen[lat] = slice_in;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic issue(input bit id, input logic [63:0] d, output bit got, output int waited,
                       output bit to);
    if (id) begin req1_valid = 1'b1; req1_data = d; end
    else begin req0_valid = 1'b1; req0_data = d; end
    wait_accept(got, waited, to);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b0; resp_ready = 1'b0;
    req0_data = '1; req1_data = '1;
    @(negedge clk); @(negedge clk);
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
    end
    checks++;
    if ({resp_valid, resp_id, resp_zero} !== 3'b000) begin
      errors++; $display("FAIL reset_resp: got %b want 000", {resp_valid, resp_id, resp_zero});
    end
    checks++;
    if (slice_in !== 16'h0) begin
      errors++; $display("FAIL reset_slice_in: got %h want 0000", slice_in);
    end
    req0_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_zero();
    bit got, to; int waited, lat;
    issue(1'b0, 64'h0, got, waited, to);
    req0_data = '1;  // must not affect the latched operand
    checks++;
    if (to !== 1'b0 || got !== 1'b0 || waited !== 0) begin
      errors++; $display("FAIL zero_accept: got to=%0b id=%0b wait=%0d want 0 0 0", to, got, waited);
    end
    wait_resp(lat, to);
    checks++;
    if (to !== 1'b0 || lat !== 4) begin
      errors++; $display("FAIL zero_latency: got %0d (to=%0b) want 4", lat, to);
    end
    checks++;
    if ({resp_id, resp_zero} !== 2'b01) begin
      errors++; $display("FAIL zero_resp: got id=%0b zero=%0b want 0 1", resp_id, resp_zero);
    end
    checks++;
    if ({seen[0], seen[1], seen[2], seen[3]} !== 64'h0) begin
      errors++; $display("FAIL zero_chunks: got %h %h %h %h want all 0000",
                         seen[0], seen[1], seen[2], seen[3]);
    end
    handshake();
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL zero_drop_valid: got %0b want 0", resp_valid);
    end
  endtask

  task automatic test_early_exit();
    bit got, to; int waited, lat;
    issue(1'b1, 64'h0000_0000_0001_0000, got, waited, to);
    req1_data = '1;
    checks++;
    if (to !== 1'b0 || got !== 1'b1) begin
      errors++; $display("FAIL early_accept: got to=%0b id=%0b want 0 1", to, got);
    end
    wait_resp(lat, to);
    checks++;
    if (to !== 1'b0 || lat !== 2) begin
      errors++; $display("FAIL early_latency: got %0d (to=%0b) want 2", lat, to);
    end
    checks++;
    if ({resp_id, resp_zero} !== 2'b10) begin
      errors++; $display("FAIL early_resp: got id=%0b zero=%0b want 1 0", resp_id, resp_zero);
    end
    checks++;
    if (seen[0] !== 16'h0000 || seen[1] !== 16'h0001) begin
      errors++; $display("FAIL early_chunks: got %h %h want 0000 0001", seen[0], seen[1]);
    end
    handshake();
  endtask

  task automatic test_round_robin();
    bit got, to; int waited, lat;
    req0_valid = 1'b1; req0_data = 64'h8000_0000_0000_0000;
    req1_valid = 1'b1; req1_data = 64'h0;
    for (int i = 0; i < 4; i++) begin
      wait_accept(got, waited, to);
      checks++;
      if (to !== 1'b0 || got !== 1'(i % 2)) begin
        errors++; $display("FAIL rr_grant%0d: got %0b (to=%0b) want %0d", i, got, to, i % 2);
      end
      wait_resp(lat, to);
      checks++;
      if (to !== 1'b0 || lat !== 4 || resp_id !== 1'(i % 2) || resp_zero !== 1'(i % 2)) begin
        errors++; $display("FAIL rr_resp%0d: got lat=%0d id=%0b zero=%0b want 4 %0d %0d",
                           i, lat, resp_id, resp_zero, i % 2, i % 2);
      end
      handshake();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_resp_hold();
    bit got, to; int waited, lat;
    issue(1'b0, 64'h1, got, waited, to);
    wait_resp(lat, to);
    checks++;
    if (to !== 1'b0 || lat !== 1) begin
      errors++; $display("FAIL hold_latency: got %0d (to=%0b) want 1", lat, to);
    end
    req1_valid = 1'b1; req1_data = 64'h0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({resp_valid, resp_id, resp_zero, req0_ready, req1_ready} !== 5'b10000) begin
        errors++; $display("FAIL hold_stable%0d: got %b want 10000", c,
                           {resp_valid, resp_id, resp_zero, req0_ready, req1_ready});
      end
      @(negedge clk);
    end
    handshake();
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req1_ready !== 1'b1) begin
      errors++; $display("FAIL hold_idle: got valid=%0b ready1=%0b want 0 1", resp_valid, req1_ready);
    end
    @(negedge clk);  // accept edge has passed
    req1_valid = 1'b0;
    wait_resp(lat, to);
    checks++;
    if (to !== 1'b0 || lat !== 4 || {resp_id, resp_zero} !== 2'b11) begin
      errors++; $display("FAIL hold_next: got lat=%0d id=%0b zero=%0b want 4 1 1",
                         lat, resp_id, resp_zero);
    end
    handshake();
  endtask

  task automatic test_reset_mid_scan();
    bit got, to; int waited, lat;
    issue(1'b0, 64'h8000_0000_0000_0000, got, waited, to);
    @(negedge clk); @(negedge clk);  // scanning chunk 2
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({resp_valid, resp_id, resp_zero, req0_ready, req1_ready} !== 5'b0 || slice_in !== 16'h0) begin
      errors++; $display("FAIL midscan_reset: got %b slice=%h want 00000 0000",
                         {resp_valid, resp_id, resp_zero, req0_ready, req1_ready}, slice_in);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++; $display("FAIL midscan_no_resp%0d: got %0b want 0", c, resp_valid);
      end
      @(negedge clk);
    end
    req0_valid = 1'b1; req0_data = 64'h0;
    req1_valid = 1'b1; req1_data = 64'h0;
    wait_accept(got, waited, to);
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (to !== 1'b0 || got !== 1'b0) begin
      errors++; $display("FAIL midscan_pointer: got %0b (to=%0b) want 0", got, to);
    end
    wait_resp(lat, to);
    handshake();
  endtask

  task automatic test_random();
    bit got, to, id; int waited, lat;
    logic [63:0] d;
    for (int i = 0; i < 200; i++) begin
      if (i < 100) d = 64'(i);
      else if (i < 164) d = 64'h1 << (i - 100);
      else begin
        d = {$urandom(), $urandom()};
        for (int k = 0; k < 4; k++) if ($urandom_range(0, 1) == 1) d[k*16 +: 16] = 16'h0;
      end
      id = 1'($urandom_range(0, 1));
      issue(id, d, got, waited, to);
      checks++;
      if (to !== 1'b0 || got !== id) begin
        errors++; $display("FAIL rand%0d_grant: got %0b (to=%0b) want %0b", i, got, to, id);
      end
      wait_resp(lat, to);
      checks++;
      if (to !== 1'b0 || lat !== exp_lat(d)) begin
        errors++; $display("FAIL rand%0d_latency: data=%h got %0d want %0d", i, d, lat, exp_lat(d));
      end
      checks++;
      if (resp_zero !== (d == 64'h0) || resp_id !== id) begin
        errors++; $display("FAIL rand%0d_resp: data=%h got zero=%0b id=%0b want %0b %0b",
                           i, d, resp_zero, resp_id, d == 64'h0, id);
      end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_early_exit();
    test_round_robin();
    test_resp_hold();
    test_reset_mid_scan();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zero_check_sched.md
Name: zero_check_sched

Overview:
- Shares one external 16-bit NOR zero-detect slice (nor16_1) between two requesters: the CBZ/branch unit and the flag-setting path.
- Sequences a WIDTH-bit operand through the slice one SLICE-wide chunk per cycle, with early exit on the first non-zero chunk.
- Returns a registered zero/non-zero result to the requester that was granted.
- Trades the extra levels of a 64-input NOR tree for multi-cycle latency in low-area builds.

Parameters:
- WIDTH, 64, operand width in bits.
- SLICE, 16, width of the external zero-detect slice. WIDTH must be an integer multiple of SLICE.
- NSLICE = WIDTH/SLICE (4 by default) is derived, not overridable.

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operand
req0_data  in  WIDTH  requester 0 operand
req0_ready  out  1  requester 0 operand accepted this cycle
req1_valid  in  1  requester 1 has an operand
req1_data  in  WIDTH  requester 1 operand
req1_ready  out  1  requester 1 operand accepted this cycle
slice_in  out  SLICE  chunk driven to the external NOR slice
slice_nor  in  1  external slice output; 1 means slice_in is all zero
resp_valid  out  1  result available
resp_id  out  1  requester the result belongs to
resp_zero  out  1  1 means the whole operand was zero
resp_ready  in  1  consumer accepts the result

Behaviour:
- States: IDLE, SCAN, RESP. Reset puts the block in IDLE.
- Reset values: req0_ready=0, req1_ready=0, resp_valid=0, resp_id=0, resp_zero=0, slice_in=0, slice index=0.
- Reset sets the round-robin pointer so that requester 0 wins the first contended grant.
- IDLE grant:
  - If only one requester is valid, that requester is granted.
  - If both are valid, the grant goes to the requester that was NOT granted last.
  - reqX_ready = (state==IDLE) && reqX_valid && grant==X. It is combinational, and at most one ready is high.
  - When ready is high, on that edge: latch the operand and id, set idx=0, set accumulator=1, record the grant for round-robin, and move to SCAN.
- SCAN:
  - slice_in = operand[idx*SLICE +: SLICE]. slice_in is 0 in every state other than SCAN.
  - slice_nor is sampled at each edge.
  - If slice_nor==0, set resp_zero=0 and move to RESP (early exit).
  - Else if idx==NSLICE-1, set resp_zero=1 and move to RESP.
  - Else idx increments.
- Latency, counting edges after the accept edge:
  - Non-zero chunk k (0-based): resp_valid goes high after k+1 edges.
  - All-zero operand: resp_valid goes high after NSLICE edges (4 by default).
- RESP:
  - resp_valid=1. resp_id and resp_zero are held stable until resp_valid && resp_ready.
  - On that handshake edge, move to IDLE and deassert resp_valid.
  - No new request is accepted in SCAN or RESP. Requesters must hold valid and data stable until their ready is seen.
- Back-to-back: at least one IDLE cycle separates a response handshake from the next accept.
- Requester data changes after accept have no effect, because the operand is latched.
- Reset mid-SCAN or mid-RESP: the in-flight operation is dropped, no response is produced, and all outputs and the pointer return to their reset values on that edge.
- Reset dominates any simultaneous valid, ready, or response handshake.
- The block does not check slice_nor for X. It assumes the slice settles within one clk period.

Test Plan:
- Reset, then req0_valid=1 with data=0 and an ideal NOR slice model → req0_ready high in cycle 1. slice_in steps through four zero chunks. resp_valid high 4 edges after accept, with resp_zero=1 and resp_id=0.
- req1 data=64'h0000_0000_0001_0000 → early exit on chunk 1. resp_valid high 2 edges after accept, resp_zero=0, resp_id=1. slice_in is never driven with chunks 2 or 3.
- Both valid continuously, with data 64'h8000_0000_0000_0000 and 0 → grants alternate 0,1,0,1 starting with 0. Each resp_id matches its grant. Responses are non-zero (4 edges) and zero (4 edges) respectively.
- Hold resp_ready=0 for 5 cycles in RESP → resp_valid, resp_id, and resp_zero stay stable and neither ready asserts. After resp_ready=1, the block returns to IDLE and accepts the next request after one cycle.
- Assert reset during SCAN idx=2 → the next edge shows all outputs at reset values and no response. The following contended request is granted to requester 0.
- Random 200 operands (including i=0..99 and single-bit patterns) from both requesters → resp_zero == (operand==0) every time, and latency matches the early-exit rule.
